// File: rtl/led_panel_scan_ctrl_if.sv
// Writer and panel-side signal bundle for the LED panel scan sequencer.
// The writer (command decoder) is the master; the scan controller is the slave.
interface led_panel_scan_ctrl_if #(
  parameter int unsigned AW = 7
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          red_out;
  logic          green_out;
  logic          blue_out;
  logic          sclk_out;
  logic          latch_out;
  logic          blank_out;
  logic          a_out;
  logic          b_out;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req,
    input  swap_ack, red_out, green_out, blue_out, sclk_out, latch_out, blank_out, a_out, b_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req,
    output swap_ack, red_out, green_out, blue_out, sclk_out, latch_out, blank_out, a_out, b_out
  );
endinterface

// File: rtl/led_panel_scan_ctrl.sv
// Row scan sequencer for a 4-row-address RGB LED panel with a double-buffered
// 1-bit-per-colour framebuffer; buffer swaps are applied only at frame boundaries.
module led_panel_scan_ctrl #(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ON_CYCLES = 128
) (
  input logic                 clk,
  input logic                 reset_n,
  led_panel_scan_ctrl_if.slave panel_io
);

  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned AW    = 2 + CW;
  localparam int unsigned MW    = AW + 1;
  localparam int unsigned Depth = 2 * 4 * COLS;
  localparam int unsigned TW    = $clog2(ON_CYCLES);

  localparam logic [TW-1:0] TLast    = TW'(ON_CYCLES - 1);
  localparam logic [TW:0]   ShiftEnd = (TW + 1)'(2 * COLS);

  typedef enum logic [1:0] {
    StShift,
    StBlank,
    StLatch
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    ab_q, ab_d;
  logic          front_q, front_d;
  logic          disp_valid_q, disp_valid_d;
  logic          swap_ack_q, swap_ack_d;
  logic          sclk_q, sclk_d;
  logic          latch_q, latch_d;
  logic          blank_q, blank_d;
  logic [2:0]    rgb_q, rgb_d;

  logic [2:0]    mem_q [Depth];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          swap_req;

  assign wr_en    = panel_io.wr_en;
  assign wr_addr  = panel_io.wr_addr;
  assign wr_data  = panel_io.wr_data;
  assign swap_req = panel_io.swap_req;

  logic [MW-1:0] wr_idx;
  logic [MW-1:0] rd_idx;
  logic [CW-1:0] rd_col;
  logic [2:0]    rd_data;

  assign wr_idx = {~front_q, wr_addr};

  // Column COLS-1 goes out first; COLS is a power of two so COLS-1-x is ~x.
  assign rd_col = ~t_d[CW:1];
  assign rd_idx = {front_d, row_d, rd_col};

  // Only on the swap cycle can the read target the buffer being written; forward it.
  assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Sequencing: row timing, row address, frame-boundary swap.
  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    row_d        = row_q;
    ab_d         = ab_q;
    front_d      = front_q;
    disp_valid_d = disp_valid_q;
    swap_ack_d   = 1'b0;
    unique case (state_q)
      StShift: begin
        if (t_q == TLast) begin
          state_d = StBlank;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StBlank: begin
        state_d = StLatch;
      end
      StLatch: begin
        state_d      = StShift;
        t_d          = '0;
        ab_d         = row_q;
        disp_valid_d = 1'b1;
        row_d        = row_q + 2'd1;
        if ((row_q == 2'd3) && swap_req) begin
          front_d    = ~front_q;
          swap_ack_d = 1'b1;
        end
      end
      default: begin
        state_d = StShift;
        t_d     = '0;
      end
    endcase
  end

  // Panel outputs for the upcoming cycle, registered so they are glitch-free.
  always_comb begin
    sclk_d  = 1'b0;
    latch_d = 1'b0;
    blank_d = 1'b1;
    rgb_d   = 3'b000;
    unique case (state_d)
      StShift: begin
        blank_d = ~disp_valid_d;
        if ({1'b0, t_d} < ShiftEnd) begin
          sclk_d = t_d[0];
          rgb_d  = t_d[0] ? rgb_q : rd_data;
        end
      end
      StBlank: begin
        blank_d = 1'b1;
      end
      StLatch: begin
        latch_d = 1'b1;
      end
      default: begin
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StShift;
      t_q          <= '0;
      row_q        <= 2'd0;
      ab_q         <= 2'd0;
      front_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      blank_q      <= 1'b1;
      rgb_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      row_q        <= row_d;
      ab_q         <= ab_d;
      front_q      <= front_d;
      disp_valid_q <= disp_valid_d;
      swap_ack_q   <= swap_ack_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      blank_q      <= blank_d;
      rgb_q        <= rgb_d;
    end
  end

  assign panel_io.swap_ack  = swap_ack_q;
  assign panel_io.red_out   = rgb_q[2];
  assign panel_io.green_out = rgb_q[1];
  assign panel_io.blue_out  = rgb_q[0];
  assign panel_io.sclk_out  = sclk_q;
  assign panel_io.latch_out = latch_q;
  assign panel_io.blank_out = blank_q;
  assign panel_io.a_out     = ab_q[0];
  assign panel_io.b_out     = ab_q[1];

endmodule
